// File: rtl/hamming_pkg.sv
// Shared SECDED (16,11) definitions used by the receive decoder and the transmit encoder.
//
// Contents:
//   state_e        - receive decoder FSM states
//   NO_ERR/ONE_ERR/TWO_ERR - 2-bit error flag encodings written alongside decoded data
//   P*_POS         - parity bit positions inside the 16-bit codeword
//   GROUP_MASK[j]  - codeword bits whose index has bit j set (parity group j)
//   extract_data   - pull b11..b1 out of a codeword
//   secded_encode  - build a codeword from an 11-bit message
package hamming_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdLo,
      StRdHi,
      StDecode,
      StWrLo,
      StWrHi,
      StDone
   } state_e;

   localparam logic [1:0] NO_ERR  = 2'b00;
   localparam logic [1:0] ONE_ERR = 2'b01;
   localparam logic [1:0] TWO_ERR = 2'b10;

   // Bit 0 is the overall parity, Hamming parity bits sit at the power-of-two positions.
   localparam int unsigned P0_POS = 0;
   localparam int unsigned P1_POS = 1;
   localparam int unsigned P2_POS = 2;
   localparam int unsigned P4_POS = 4;
   localparam int unsigned P8_POS = 8;

   localparam logic [3:0][15:0] GROUP_MASK = {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA};

   // Data b1..b11 live at positions 3, 5, 6, 7, 9..15 (b1 is the LSB of the result).
   function automatic logic [10:0] extract_data(input logic [15:0] cw);
      return {cw[15:9], cw[7:5], cw[3]};
   endfunction

   function automatic logic [15:0] secded_encode(input logic [10:0] d);
      logic [15:0] cw;
      cw       = '0;
      cw[15:9] = d[10:4];
      cw[7:5]  = d[3:1];
      cw[3]    = d[0];
      // Parity positions are still zero here, so each group XOR only sees data bits.
      cw[P1_POS] = ^(cw & GROUP_MASK[0]);
      cw[P2_POS] = ^(cw & GROUP_MASK[1]);
      cw[P4_POS] = ^(cw & GROUP_MASK[2]);
      cw[P8_POS] = ^(cw & GROUP_MASK[3]);
      cw[P0_POS] = ^cw;
      return cw;
   endfunction

endpackage

// File: rtl/secded_decode.sv
// Combinational SECDED (16,11) decoder.
//
// Ports:
//   cw    - 16-bit received codeword (bit k = Hamming position k, bit 0 = overall parity)
//   data  - corrected message b11..b1 (uncorrected on a double error)
//   flags - NO_ERR, ONE_ERR (bit corrected) or TWO_ERR (detected, not corrected)
module secded_decode
   import hamming_pkg::*;
(
   input  logic [15:0] cw,
   output logic [10:0] data,
   output logic [1:0]  flags
);

   logic [3:0]  syn;
   logic        par;
   logic [15:0] fixed;

   always_comb begin
      syn = '0;
      for (int j = 0; j < 4; j++) begin
         syn[j] = ^(cw & GROUP_MASK[j]);
      end
      par   = ^cw;
      fixed = cw;
      flags = NO_ERR;
      if (par) begin
         // Odd overall parity: one flipped bit at position syn (syn == 0 means p0 itself).
         fixed[syn] = ~cw[syn];
         flags      = ONE_ERR;
      end else if (syn != 4'd0) begin
         flags = TWO_ERR;
      end
      data = extract_data(fixed);
   end

endmodule

// File: rtl/hamming_rx_decoder.sv
// Receive-side SECDED decoder: reads NUM_MSG two-byte codewords from SRC_BASE, decodes each
// and writes two result bytes per message to DST_BASE, then raises done.
//
// Ports:
//   clk      - clock, rising edge
//   init_n   - asynchronous active-low reset
//   start    - run request, honoured in idle and done
//   raddr    - memory read address; data_out is the combinational read data
//   waddr    - memory write address; data_in is the write data, write_en the store strobe
//   done     - run complete, held until the next start
module hamming_rx_decoder
   import hamming_pkg::*;
#(
   parameter int unsigned W          = 8,
   parameter int unsigned BYTE_COUNT = 256,
   parameter int unsigned SRC_BASE   = 30,
   parameter int unsigned DST_BASE   = 0,
   parameter int unsigned NUM_MSG    = 15
) (
   input  logic         clk,
   input  logic         init_n,
   input  logic         start,
   output logic [7:0]   raddr,
   input  logic [W-1:0] data_out,
   output logic [7:0]   waddr,
   output logic [W-1:0] data_in,
   output logic         write_en,
   output logic         done
);

   localparam int unsigned AW = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
   // Addresses wrap inside the memory; the 8-bit ports cap that at 256 bytes.
   localparam logic [7:0] ADDR_MASK = (AW >= 8) ? 8'hFF : 8'((1 << AW) - 1);
   localparam int unsigned IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);
   localparam logic [7:0] SRC_B = 8'(SRC_BASE);
   localparam logic [7:0] DST_B = 8'(DST_BASE);

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [15:0]   cw_q, cw_d;
   logic [12:0]   res_q, res_d;  // {flags, data[10:0]}
   logic          done_q;

   logic [10:0] dec_data;
   logic [1:0]  dec_flags;
   logic [7:0]  offset;

   secded_decode u_decode (
      .cw    (cw_q),
      .data  (dec_data),
      .flags (dec_flags)
   );

   assign offset = 8'({idx_q, 1'b0});

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cw_d     = cw_q;
      res_d    = res_q;
      raddr    = '0;
      waddr    = '0;
      data_in  = '0;
      write_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               idx_d   = '0;
               state_d = StRdLo;
            end
         end
         StRdLo: begin
            raddr      = (SRC_B + offset) & ADDR_MASK;
            cw_d[7:0]  = data_out[7:0];
            state_d    = StRdHi;
         end
         StRdHi: begin
            raddr      = (SRC_B + offset + 8'd1) & ADDR_MASK;
            cw_d[15:8] = data_out[7:0];
            state_d    = StDecode;
         end
         StDecode: begin
            res_d   = {dec_flags, dec_data};
            state_d = StWrLo;
         end
         StWrLo: begin
            write_en = 1'b1;
            waddr    = (DST_B + offset) & ADDR_MASK;
            data_in  = W'(res_q[7:0]);
            state_d  = StWrHi;
         end
         StWrHi: begin
            write_en = 1'b1;
            waddr    = (DST_B + offset + 8'd1) & ADDR_MASK;
            data_in  = W'({res_q[12:11], 3'b000, res_q[10:8]});
            if (idx_q == LAST_IDX) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = StRdLo;
            end
         end
         StDone: begin
            if (start) begin
               idx_d   = '0;
               state_d = StRdLo;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cw_q    <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cw_q    <= cw_d;
         res_q   <= res_d;
         done_q  <= (state_d == StDone);
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_hamming_rx_decoder.sv
// Scoreboard bench for hamming_rx_decoder: expected writes are queued per run and a negedge
// monitor compares every DUT store against the queue head.
module tb_hamming_rx_decoder;
   import hamming_pkg::*;

   localparam int unsigned SRC = 30;
   localparam int unsigned DST = 0;
   localparam int unsigned N   = 15;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk    = 1'b0;
   logic       init_n = 1'b0;
   logic       start  = 1'b0;
   logic [7:0] raddr, waddr, data_in, data_out;
   logic       write_en, done;

   logic [7:0]  rom [256];
   logic [7:0]  ram [256];
   logic [15:0] cw_tab [N];
   logic [7:0]  lo_tab [N];
   logic [7:0]  hi_tab [N];
   wr_t         exp_q [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign data_out = rom[raddr];

   hamming_rx_decoder #(
      .W          (8),
      .BYTE_COUNT (256),
      .SRC_BASE   (SRC),
      .DST_BASE   (DST),
      .NUM_MSG    (N)
   ) dut (
      .clk      (clk),
      .init_n   (init_n),
      .start    (start),
      .raddr    (raddr),
      .data_out (data_out),
      .waddr    (waddr),
      .data_in  (data_in),
      .write_en (write_en),
      .done     (done)
   );

   always @(posedge clk) begin
      if (write_en) ram[waddr] <= data_in;
   end

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   // Monitor: every store must match the oldest outstanding expected write.
   always @(negedge clk) begin
      wr_t e;
      if (init_n && write_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write actual=%0h:%0h required=none", waddr, data_in);
         end else begin
            e = exp_q.pop_front();
            if (waddr !== e.addr || data_in !== e.data) begin
               errors++;
               $display("FAIL write actual=%0h:%0h required=%0h:%0h", waddr, data_in,
                        e.addr, e.data);
            end
         end
      end
   end

   // Reference: message bits are the non-power-of-two positions 3..15 in ascending order.
   function automatic logic [10:0] ref_extract(input logic [15:0] w);
      logic [10:0] d;
      int n;
      d = '0;
      n = 0;
      for (int k = 3; k < 16; k++) begin
         if ((k & (k - 1)) != 0) begin
            d[n] = w[k];
            n++;
         end
      end
      return d;
   endfunction

   task automatic set_slot(input int i, input logic [15:0] w, input logic [7:0] lo,
                           input logic [7:0] hi);
      cw_tab[i] = w;
      lo_tab[i] = lo;
      hi_tab[i] = hi;
   endtask

   task automatic clear_slots();
      for (int i = 0; i < N; i++) set_slot(i, 16'h0000, 8'h00, 8'h00);
   endtask

   // Random message, 0..2 distinct bit flips; expectation from the known ground truth.
   task automatic rand_slot(input int i);
      logic [10:0] d, ed;
      logic [15:0] w;
      logic [1:0]  f;
      int nf, p1, p2;
      d  = 11'($urandom);
      w  = secded_encode(d);
      nf = $urandom_range(2, 0);
      p1 = $urandom_range(15, 0);
      p2 = (p1 + $urandom_range(15, 1)) % 16;
      ed = d;
      f  = 2'b00;
      if (nf >= 1) w[p1] = ~w[p1];
      if (nf == 1) f = 2'b01;
      if (nf == 2) begin
         w[p2] = ~w[p2];
         f     = 2'b10;
         ed    = ref_extract(w);
      end
      set_slot(i, w, ed[7:0], {f, 3'b000, ed[10:8]});
   endtask

   task automatic load_rom();
      for (int i = 0; i < N; i++) begin
         rom[SRC + 2 * i]     = cw_tab[i][7:0];
         rom[SRC + 2 * i + 1] = cw_tab[i][15:8];
      end
   endtask

   task automatic push_expected(input int count);
      for (int i = 0; i < count; i++) begin
         exp_q.push_back('{addr: 8'(DST + 2 * i), data: lo_tab[i]});
         exp_q.push_back('{addr: 8'(DST + 2 * i + 1), data: hi_tab[i]});
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_and_check(input string name);
      int n;
      load_rom();
      push_expected(N);
      pulse_start();
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         n++;
         #1;
         if (done) break;
      end
      check({name, "_done_edges"}, n, 75);
      check({name, "_pending"}, exp_q.size(), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         check({name, "_mem_lo"}, ram[DST + 2 * i], lo_tab[i]);
         check({name, "_mem_hi"}, ram[DST + 2 * i + 1], hi_tab[i]);
      end
      repeat (3) @(posedge clk);
      #1 check({name, "_done_hold"}, done, 1'b1);
   endtask

   task automatic reset_mid_run();
      int n;
      for (int i = 0; i < N; i++) rand_slot(i);
      load_rom();
      push_expected(7);
      pulse_start();
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         n++;
         #1;
         if (write_en && waddr == 8'(DST + 14)) break;
      end
      check("msg7_wrlo_reached", n < 200, 1'b1);
      check("msg0_6_written", exp_q.size(), 0);
      #1 init_n = 1'b0;
      #1;
      check("rst_write_en", write_en, 1'b0);
      check("rst_done", done, 1'b0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk) init_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 check("idle_done", done, 1'b0);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         rom[a] = 8'h00;
      end
      #1;
      check("reset_done", done, 1'b0);
      check("reset_write_en", write_en, 1'b0);
      check("reset_raddr", raddr, 8'h00);
      check("reset_waddr", waddr, 8'h00);
      check("reset_data_in", data_in, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk) init_n = 1'b1;
      repeat (2) @(posedge clk);

      clear_slots();
      run_and_check("zeros");

      clear_slots();
      set_slot(0, 16'hFFFF, 8'hFF, 8'h07);
      run_and_check("clean_ffff");
      set_slot(0, 16'hFFDF, 8'hFF, 8'h47);
      run_and_check("flip_bit5");
      set_slot(0, 16'hFFFE, 8'hFF, 8'h47);
      run_and_check("flip_p0");
      set_slot(0, 16'hFFD7, 8'hFC, 8'h87);
      run_and_check("double_5_3");

      reset_mid_run();
      for (int i = 0; i < N; i++) rand_slot(i);
      run_and_check("after_reset");

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++) rand_slot(i);
         run_and_check("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
